signed_solve_v: RTL and testbench



---
 rtl/signed_solve_v.sv | 170 +++++++++++++++++
 tb/tb_signed_solve_v.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/signed_solve_v.sv
// signed_solve_v
// Exhaustive inverse of the signed 6X-11Y calculator.
// A signed target F is captured on start. Every signed W_IN-bit pair (X, Y)
// is then tried, one per cycle. X is the outer loop and Y the inner loop,
// both ascending. Each pair with 6X - 11Y == F is offered over a
// valid/ready handshake. The run ends with a one-cycle done pulse, and the
// count of accepted results is presented alongside it.
//
// Optional feature macro: SIGNED_SOLVE_FIRST_ONLY_EN
//   When defined, the run ends right after the first accepted result.
//   A run without any match still scans every candidate.
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   i_start   start request, only honoured in IDLE
//   i_fs      signed target F (W_IN+4 bits), captured with i_start
//   i_ready   consumer accepts the presented result
//   o_valid   o_xs/o_ys hold a solution
//   o_xs      signed X of the solution
//   o_ys      signed Y of the solution
//   o_busy    high whenever not IDLE
//   o_done    one-cycle pulse at the end of the run
//   o_count   accepted results in this run, saturating at 255
module signed_solve_v #(
    parameter int W_IN = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [W_IN+3:0]   i_fs,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [W_IN-1:0]   o_xs,
    output logic [W_IN-1:0]   o_ys,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int VW = W_IN + 5;
    localparam logic [W_IN-1:0] MIN_V = {1'b1, {(W_IN-1){1'b0}}};
    localparam logic [W_IN-1:0] MAX_V = {1'b0, {(W_IN-1){1'b1}}};

    state_t          state;
    state_t          state_nxt;
    logic [W_IN+3:0] target;
    logic [W_IN-1:0] x;
    logic [W_IN-1:0] y;
    logic [W_IN-1:0] x_nxt;
    logic [W_IN-1:0] y_nxt;
    logic [VW-1:0]   x_ext;
    logic [VW-1:0]   y_ext;
    logic [VW-1:0]   t_ext;
    logic [VW-1:0]   value;
    logic            match;
    logic            last;
    logic            accept;

    // The candidate value is formed at W_IN+5 bits, which is wide enough
    // that 6x - 11y never wraps. A target that lies outside the W_IN+4-bit
    // range therefore cannot produce a false match.
    always_comb begin
        x_ext = {{5{x[W_IN-1]}}, x};
        y_ext = {{5{y[W_IN-1]}}, y};
        t_ext = {target[W_IN+3], target};
        value = ((x_ext << 2) + (x_ext << 1))
              - ((y_ext << 3) + (y_ext << 1) + y_ext);
        match = (value == t_ext);
        last  = (x == MAX_V) && (y == MAX_V);
    end

    // Advance the scan: Y sweeps fastest, and X steps when Y wraps.
    always_comb begin
        x_nxt = x;
        y_nxt = y + 1'b1;
        if (y == MAX_V) begin
            y_nxt = MIN_V;
            x_nxt = x + 1'b1;
        end
    end

    assign accept = (state == RESP) && i_ready;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = SEARCH;
            end
            SEARCH: begin
                if (match)     state_nxt = RESP;
                else if (last) state_nxt = DONE;
            end
            RESP: begin
                if (i_ready) begin
`ifdef SIGNED_SOLVE_FIRST_ONLY_EN
                    state_nxt = DONE;
`else
                    state_nxt = last ? DONE : SEARCH;
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_busy = (state != IDLE);
        o_done = (state == DONE);
    end

    // Datapath. The scan counter holds on a match, so the matching pair is
    // still current while the result waits in RESP. It steps only once the
    // result is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            target  <= '0;
            x       <= MIN_V;
            y       <= MIN_V;
            o_valid <= 1'b0;
            o_xs    <= '0;
            o_ys    <= '0;
            o_count <= '0;
        end else begin
            if (state == IDLE && i_start) begin
                target  <= i_fs;
                x       <= MIN_V;
                y       <= MIN_V;
                o_count <= '0;
            end else if (state == SEARCH) begin
                if (match) begin
                    o_xs    <= x;
                    o_ys    <= y;
                    o_valid <= 1'b1;
                end else begin
                    x <= x_nxt;
                    y <= y_nxt;
                end
            end else if (accept) begin
                o_valid <= 1'b0;
                x       <= x_nxt;
                y       <= y_nxt;
                if (o_count != 8'hFF) o_count <= o_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_signed_solve_v.sv
// tb_signed_solve_v
// Self-checking bench for signed_solve_v (W_IN = 5).
// The reference model enumerates every (X, Y) pair with plain integer
// arithmetic and queues the solutions of 6X - 11Y = F in scan order. It also
// predicts the edge on which o_done is seen, counted from the start edge E0.
// Defining SIGNED_SOLVE_FIRST_ONLY_EN retargets the model to first-only mode.
module tb_signed_solve_v;

    localparam int W  = 5;
    localparam int FW = W + 4;
    localparam int LO = -(1 << (W - 1));
    localparam int HI = (1 << (W - 1)) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [FW-1:0] i_fs = '0;
    logic          i_ready = 1'b1;
    logic          o_valid;
    logic [W-1:0]  o_xs;
    logic [W-1:0]  o_ys;
    logic          o_busy;
    logic          o_done;
    logic [7:0]    o_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x;
        int y;
        int idx;
    } sol_t;

    sol_t expQ[$];

    signed_solve_v #(.W_IN(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_fs    (i_fs),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_xs    (o_xs),
        .o_ys    (o_ys),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference model: brute-force enumeration in scan order.
    task automatic buildModel(input int f);
        int idx;
        sol_t s;
        expQ.delete();
        idx = 0;
        for (int x = LO; x <= HI; x++) begin
            for (int y = LO; y <= HI; y++) begin
                if (6 * x - 11 * y == f) begin
                    s.x = x;
                    s.y = y;
                    s.idx = idx;
                    expQ.push_back(s);
                end
                idx++;
            end
        end
`ifdef SIGNED_SOLVE_FIRST_ONLY_EN
        while (expQ.size() > 1) void'(expQ.pop_back());
`endif
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_valid"}, int'(o_valid), 0);
        checkOutput({tag, "_xs"},    int'(o_xs),    0);
        checkOutput({tag, "_ys"},    int'(o_ys),    0);
        checkOutput({tag, "_busy"},  int'(o_busy),  0);
        checkOutput({tag, "_done"},  int'(o_done),  0);
        checkOutput({tag, "_count"}, int'(o_count), 0);
    endtask

    // mode 0: ready held high
    // mode 1: ready low for 10 cycles at the first result
    // mode 2: random ready, plus a stray start pulse mid-run
    // mode 3: async reset while the first result waits in RESP
    task automatic applyStimulus(input int f, input int mode);
        int   edges;
        int   stall;
        int   stallLeft;
        int   expNum;
        int   firstIdx;
        int   expEdge;
        bit   doneSeen;
        bit   rdy;
        sol_t s;

        buildModel(f);
        expNum   = expQ.size();
        firstIdx = (expNum > 0) ? expQ[0].idx : -1;

        @(negedge i_clk);
        i_fs    = f[FW-1:0];
        i_start = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_fs    = FW'($urandom);

        edges     = 0;
        stall     = 0;
        stallLeft = (mode == 1) ? 10 : 0;
        doneSeen  = 1'b0;

        while (!doneSeen && edges < 3000) begin
            @(negedge i_clk);
            if (edges == 0) checkOutput("busy_after_start", int'(o_busy), 1);
            i_start = (mode == 2 && edges == 50);
            if (o_valid && o_done) checkOutput("valid_done_exclusive", 1, 0);
            if (o_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_result", 1, 0);
                    rdy = 1'b1;
                end else begin
                    s = expQ[0];
                    checkOutput("result_x", int'($signed(o_xs)), s.x);
                    checkOutput("result_y", int'($signed(o_ys)), s.y);
                    if (mode == 3) begin
                        i_rst_n = 1'b0;
                        #1;
                        checkZeroOutputs("reset_in_resp");
                        @(negedge i_clk);
                        checkZeroOutputs("reset_held");
                        i_rst_n = 1'b1;
                        return;
                    end
                    rdy = 1'b1;
                    if (mode == 1 && stallLeft > 0) begin
                        rdy = 1'b0;
                        stallLeft--;
                    end else if (mode == 2) begin
                        rdy = ($urandom_range(0, 3) != 0);
                    end
                end
                i_ready = rdy;
                if (rdy) void'(expQ.pop_front());
                else     stall++;
            end else begin
                i_ready = (mode == 2) ? 1'($urandom) : 1'b1;
            end
            if (o_done) begin
                doneSeen = 1'b1;
`ifdef SIGNED_SOLVE_FIRST_ONLY_EN
                expEdge = (expNum > 0) ? firstIdx + 3 + stall : 1025;
`else
                expEdge = 1025 + expNum + stall;
`endif
                checkOutput("done_edge", edges + 1, expEdge);
                checkOutput("done_count", int'(o_count), (expNum > 255) ? 255 : expNum);
                checkOutput("results_left", expQ.size(), 0);
                checkOutput("busy_at_done", int'(o_busy), 1);
            end
            edges++;
        end

        if (!doneSeen) begin
            checkOutput("timeout", 1, 0);
        end else begin
            @(negedge i_clk);
            checkOutput("idle_busy", int'(o_busy), 0);
            checkOutput("idle_done", int'(o_done), 0);
            checkOutput("count_hold", int'(o_count), (expNum > 255) ? 255 : expNum);
        end
        i_start = 1'b0;
        i_ready = 1'b1;
    endtask

    initial begin
        #12;
        checkZeroOutputs("reset_state");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(255, 0);
        applyStimulus(-256, 0);
        applyStimulus(1, 1);
        applyStimulus(1, 3);
        applyStimulus(0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(int'($urandom_range(0, 511)) - 256, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
